// File: rtl/ap_sched_pkg.sv
// rtl/ap_sched_pkg.sv - shared state, opcode and burst-length definitions for ap_cmd_scheduler
package ap_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_XFER,
    WR_XFER,
    DONE
  } sched_state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam int DEF_RD_BURST       = 8;
  localparam int DEF_WR_BURST       = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, preference flips after every grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // rr=0 prefers requester 0, rr=1 prefers requester 1
  logic rr;

  // Grant the preferred requester if it asks, otherwise fall back to the other one
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (!rr) begin
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
      end else begin
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
      end
    end
  end

  // Hand preference to the source that was not just served
  always_ff @(posedge clk) begin
    if (!rst_n)      rr <= 1'b0;
    else if (gnt[0]) rr <= 1'b1;
    else if (gnt[1]) rr <= 1'b0;
  end

endmodule

// File: rtl/ap_cmd_scheduler.sv
// rtl/ap_cmd_scheduler.sv - instruction sequencer issuing DMA bursts and moving beats; optional watchdog under AP_SCHED_TIMEOUT_EN
module ap_cmd_scheduler
  import ap_sched_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int OP_W           = 2,
  parameter int RD_BURST       = DEF_RD_BURST,
  parameter int WR_BURST       = DEF_WR_BURST,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   isa_empty,
  input  logic [OP_W+ADDR_W-1:0] isa_dout,
  output logic                   isa_rd_en,
  output logic                   dma_cmd_valid,
  input  logic                   dma_cmd_ready,
  output logic [ADDR_W-1:0]      dma_cmd_addr,
  output logic [7:0]             dma_cmd_len,
  output logic                   dma_cmd_wr,
  input  logic                   dma_rd_empty,
  input  logic [DATA_W-1:0]      dma_rd_dout,
  output logic                   dma_rd_en,
  input  logic                   aeq_full,
  output logic [DATA_W-1:0]      aeq_din,
  output logic                   aeq_wr_en,
  input  logic                   eaq1_empty,
  input  logic [DATA_W-1:0]      eaq1_dout,
  output logic                   eaq1_rd_en,
  input  logic                   eaq2_empty,
  input  logic [DATA_W-1:0]      eaq2_dout,
  output logic                   eaq2_rd_en,
  input  logic                   dma_wr_full,
  output logic [DATA_W-1:0]      dma_wr_din,
  output logic                   dma_wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   timeout
);

  localparam logic [7:0] RD_LEN = 8'(RD_BURST);
  localparam logic [7:0] WR_LEN = 8'(WR_BURST);

  sched_state_t      state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        beat_cnt;
  logic              err_q;
  logic              beat;
  logic              stall_hit;
  logic              arb_en;
  logic [1:0]        gnt;
  logic [OP_W-1:0]   isa_op;

  assign isa_op = isa_dout[ADDR_W +: OP_W];

  // Descriptor fields come straight from the latched instruction, so they hold until accepted
  assign dma_cmd_addr = addr_q;
  assign dma_cmd_len  = op_q[1] ? WR_LEN : RD_LEN;
  assign dma_cmd_wr   = op_q[1];
  assign aeq_din      = dma_rd_dout;
  assign dma_wr_din   = gnt[1] ? eaq2_dout : eaq1_dout;
  assign busy         = (state != IDLE);
  assign err          = err_q;

  // Arbiter only grants while a write burst can push into the DMA write FIFO
  assign arb_en = rst_n && (state == WR_XFER) && !dma_wr_full;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({!eaq2_empty, !eaq1_empty}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  // Next state and strobes; everything is held low while reset is asserted
  always_comb begin
    state_nxt     = state;
    isa_rd_en     = 1'b0;
    dma_cmd_valid = 1'b0;
    dma_rd_en     = 1'b0;
    aeq_wr_en     = 1'b0;
    eaq1_rd_en    = 1'b0;
    eaq2_rd_en    = 1'b0;
    dma_wr_en     = 1'b0;
    done          = 1'b0;
    beat          = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (!isa_empty) begin
            isa_rd_en = 1'b1;
            if (isa_op == OP_READ || isa_op == OP_WRITE) state_nxt = CMD;
          end
        end
        CMD: begin
          dma_cmd_valid = 1'b1;
          if (dma_cmd_ready) state_nxt = op_q[1] ? WR_XFER : RD_XFER;
        end
        RD_XFER: begin
          beat      = !dma_rd_empty && !aeq_full;
          dma_rd_en = beat;
          aeq_wr_en = beat;
          if ((beat && beat_cnt == 8'd1) || (!beat && stall_hit)) state_nxt = DONE;
        end
        WR_XFER: begin
          beat       = |gnt;
          eaq1_rd_en = gnt[0];
          eaq2_rd_en = gnt[1];
          dma_wr_en  = beat;
          if ((beat && beat_cnt == 8'd1) || (!beat && stall_hit)) state_nxt = DONE;
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, latched instruction, beat counter and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (isa_rd_en) begin
        op_q   <= isa_op;
        addr_q <= isa_dout[ADDR_W-1:0];
        if (isa_op == OP_ILL) err_q <= 1'b1;
      end
      if (dma_cmd_valid && dma_cmd_ready) beat_cnt <= dma_cmd_len;
      else if (beat)                      beat_cnt <= beat_cnt - 8'd1;
    end
  end

`ifdef AP_SCHED_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt;
  logic        timeout_q;
  logic        in_xfer;

  assign in_xfer   = (state == RD_XFER) || (state == WR_XFER);
  assign stall_hit = (stall_cnt == STALL_LAST);
  assign timeout   = timeout_q;

  // Count consecutive beat-less transfer cycles; the last one forces DONE and latches timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (!in_xfer || beat) begin
      stall_cnt <= '0;
    end else if (stall_hit) begin
      stall_cnt <= '0;
      timeout_q <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Watchdog compiled out: bursts wait forever; the limit is only kept in the parameter list
  assign stall_hit = 1'b0;
  assign timeout   = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_ap_cmd_scheduler.sv
// tb/tb_ap_cmd_scheduler.sv - scoreboard bench for ap_cmd_scheduler
module tb_ap_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        isa_empty;
  logic [33:0] isa_dout;
  logic        isa_rd_en;
  logic        dma_cmd_valid, dma_cmd_ready;
  logic [31:0] dma_cmd_addr;
  logic [7:0]  dma_cmd_len;
  logic        dma_cmd_wr;
  logic        dma_rd_empty, dma_rd_en;
  logic [63:0] dma_rd_dout;
  logic        aeq_full, aeq_wr_en;
  logic [63:0] aeq_din;
  logic        eaq1_empty, eaq1_rd_en, eaq2_empty, eaq2_rd_en;
  logic [63:0] eaq1_dout, eaq2_dout;
  logic        dma_wr_full, dma_wr_en;
  logic [63:0] dma_wr_din;
  logic        busy, done, err, timeout;

  always #5 clk = ~clk;

  ap_cmd_scheduler #(
    .ADDR_W(32), .DATA_W(64), .OP_W(2), .RD_BURST(8), .WR_BURST(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .isa_empty(isa_empty), .isa_dout(isa_dout), .isa_rd_en(isa_rd_en),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_addr(dma_cmd_addr), .dma_cmd_len(dma_cmd_len), .dma_cmd_wr(dma_cmd_wr),
    .dma_rd_empty(dma_rd_empty), .dma_rd_dout(dma_rd_dout), .dma_rd_en(dma_rd_en),
    .aeq_full(aeq_full), .aeq_din(aeq_din), .aeq_wr_en(aeq_wr_en),
    .eaq1_empty(eaq1_empty), .eaq1_dout(eaq1_dout), .eaq1_rd_en(eaq1_rd_en),
    .eaq2_empty(eaq2_empty), .eaq2_dout(eaq2_dout), .eaq2_rd_en(eaq2_rd_en),
    .dma_wr_full(dma_wr_full), .dma_wr_din(dma_wr_din), .dma_wr_en(dma_wr_en),
    .busy(busy), .done(done), .err(err), .timeout(timeout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        wr;
    int          vcyc;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [63:0] exp_aeq[$];
  logic [63:0] exp_wr[$];
  logic [33:0] isa_q[$];
  logic [63:0] rd_q[$], e1_q[$], e2_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cmd_delay = 1;
  int   vcnt = 0;
  int   done_cnt = 0, pop_cnt = 0, rd_beats = 0, wr_beats = 0;
  int   aeq_stall_at = -1, aeq_stall_left = 0;
  logic rd_hold = 1'b0;
  logic prev_done = 1'b0;
  logic p_isa, p_rd, p_e1, p_e2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FWFT source FIFO models: pop what the DUT read, then present the new head
  always begin
    @(negedge clk);
    p_isa = isa_rd_en; p_rd = dma_rd_en; p_e1 = eaq1_rd_en; p_e2 = eaq2_rd_en;
    @(posedge clk);
    #1;
    if (p_isa && isa_q.size() > 0) void'(isa_q.pop_front());
    if (p_rd && rd_q.size() > 0)   void'(rd_q.pop_front());
    if (p_e1 && e1_q.size() > 0)   void'(e1_q.pop_front());
    if (p_e2 && e2_q.size() > 0)   void'(e2_q.pop_front());
    #1;
    isa_empty    = (isa_q.size() == 0);
    isa_dout     = isa_empty ? '0 : isa_q[0];
    dma_rd_empty = rd_hold || (rd_q.size() == 0);
    dma_rd_dout  = (rd_q.size() == 0) ? '0 : rd_q[0];
    eaq1_empty   = (e1_q.size() == 0);
    eaq1_dout    = eaq1_empty ? '0 : e1_q[0];
    eaq2_empty   = (e2_q.size() == 0);
    eaq2_dout    = eaq2_empty ? '0 : e2_q[0];
    dma_cmd_ready = (vcnt >= cmd_delay - 1);
    if (aeq_stall_left > 0 && rd_beats == aeq_stall_at) begin
      aeq_full = 1'b1;
      aeq_stall_left--;
    end else begin
      aeq_full = 1'b0;
    end
  end

  // Monitor: compare every DUT output event against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_strobes", {isa_rd_en, dma_cmd_valid, dma_rd_en, aeq_wr_en,
                              eaq1_rd_en, eaq2_rd_en, dma_wr_en, done}, 8'h00);
    end else begin
      if (isa_rd_en) begin
        pop_cnt++;
        check("isa_pop_gate", isa_empty, 1'b0);
      end
      if (dma_cmd_valid) begin
        vcnt++;
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected actual addr=%0h required=none", dma_cmd_addr);
        end else begin
          check("cmd_addr", dma_cmd_addr, exp_cmd[0].addr);
          check("cmd_len", dma_cmd_len, exp_cmd[0].len);
          check("cmd_wr", dma_cmd_wr, exp_cmd[0].wr);
          if (dma_cmd_ready) begin
            check("cmd_valid_cycles", vcnt, exp_cmd[0].vcyc);
            void'(exp_cmd.pop_front());
          end
        end
        if (dma_cmd_ready) vcnt = 0;
      end
      if (dma_rd_en || aeq_wr_en) begin
        check("rd_gate", {dma_rd_en, aeq_wr_en, dma_rd_empty, aeq_full}, 4'b1100);
        rd_beats++;
        if (exp_aeq.size() == 0) begin
          checks++; errors++;
          $display("FAIL aeq_unexpected actual=%0h required=none", aeq_din);
        end else begin
          check("aeq_data", aeq_din, exp_aeq.pop_front());
        end
      end
      if (dma_wr_en || eaq1_rd_en || eaq2_rd_en) begin
        check("wr_gate", {dma_wr_en, dma_wr_full, eaq1_rd_en & eaq1_empty,
                          eaq2_rd_en & eaq2_empty, eaq1_rd_en ^ eaq2_rd_en}, 5'b10001);
        wr_beats++;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected actual=%0h required=none", dma_wr_din);
        end else begin
          check("wr_data", dma_wr_din, exp_wr.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 1'b0);
      end
    end
    prev_done = done;
  end

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) tick();
    check("done_count", done_cnt, target);
    tick(); tick();
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic queue_read(input logic [31:0] addr, input int vcyc, input logic [7:0] tag);
    for (int i = 0; i < 8; i++) begin
      rd_q.push_back({tag, 56'(i)});
      exp_aeq.push_back({tag, 56'(i)});
    end
    exp_cmd.push_back('{addr: addr, len: 8'd8, wr: 1'b0, vcyc: vcyc});
    isa_q.push_back({2'b01, addr});
  endtask

  task automatic load_eaq(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      e1_q.push_back({8'hE1, base, 48'(i)});
      e2_q.push_back({8'hE2, base, 48'(i)});
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0; isa_empty = 1'b1; isa_dout = '0; dma_cmd_ready = 1'b0;
    dma_rd_empty = 1'b1; dma_rd_dout = '0; aeq_full = 1'b0;
    eaq1_empty = 1'b1; eaq1_dout = '0; eaq2_empty = 1'b1; eaq2_dout = '0; dma_wr_full = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_timeout", timeout, 1'b0);

    // READ with descriptor accepted on the third valid cycle
    cmd_delay = 3;
    queue_read(32'h1000_0000, 3, 8'hA0);
    wait_done(1);
    check("t1_beats", rd_beats, 8);
    check("t1_pops", pop_cnt, 1);

    // Two WRITEs with both engine queues always populated: strict alternation, EAQ1 first each time
    cmd_delay = 1;
    load_eaq(16, 8'h01);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) begin
        exp_wr.push_back({8'hE1, 8'h01, 48'(b * 8 + i)});
        exp_wr.push_back({8'hE2, 8'h01, 48'(b * 8 + i)});
      end
    exp_cmd.push_back('{addr: 32'h2000_0000, len: 8'd16, wr: 1'b1, vcyc: 1});
    exp_cmd.push_back('{addr: 32'h2000_1000, len: 8'd16, wr: 1'b1, vcyc: 1});
    isa_q.push_back({2'b10, 32'h2000_0000});
    isa_q.push_back({2'b10, 32'h2000_1000});
    wait_done(3);
    check("t2_wr_beats", wr_beats, 32);

    // READ with AEQ full for three cycles after the second beat
    aeq_stall_at = rd_beats + 2;
    aeq_stall_left = 3;
    queue_read(32'h1000_4000, 1, 8'hB0);
    wait_done(4);
    check("t3_stall_applied", aeq_stall_left, 0);
    check("t3_beats", rd_beats, 16);

    // Illegal, NOP, then READ: only the READ issues a descriptor
    check("t4_err_before", err, 1'b0);
    base = pop_cnt;
    isa_q.push_back({2'b11, 32'hDEAD_BEEF});
    isa_q.push_back({2'b00, 32'h0000_0044});
    queue_read(32'h3000_0000, 1, 8'hC0);
    for (int i = 0; i < 50 && pop_cnt == base; i++) tick();
    check("t4_err_after_pop", err, 1'b1);
    wait_done(5);
    check("t4_pops", pop_cnt - base, 3);
    check("t4_err_sticky", err, 1'b1);

    // Reset after five WRITE beats: abort without done, rr back to EAQ1
    load_eaq(8, 8'h02);
    exp_wr.push_back({8'hE1, 8'h02, 48'd0});
    exp_wr.push_back({8'hE2, 8'h02, 48'd0});
    exp_wr.push_back({8'hE1, 8'h02, 48'd1});
    exp_wr.push_back({8'hE2, 8'h02, 48'd1});
    exp_wr.push_back({8'hE1, 8'h02, 48'd2});
    exp_cmd.push_back('{addr: 32'h2000_2000, len: 8'd16, wr: 1'b1, vcyc: 1});
    isa_q.push_back({2'b10, 32'h2000_2000});
    base = wr_beats;
    for (int i = 0; i < 100 && wr_beats < base + 5; i++) tick();
    check("t5_beats_before_reset", wr_beats - base, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_reset_busy", busy, 1'b0);
    check("t5_post_reset_err", err, 1'b0);
    check("t5_post_reset_strobes", {isa_rd_en, dma_cmd_valid, dma_rd_en, aeq_wr_en,
                                    eaq1_rd_en, eaq2_rd_en, dma_wr_en, done}, 8'h00);
    tick(); tick(); tick();
    check("t5_no_done", done_cnt, 5);
    check("t5_scoreboard_drained", exp_wr.size(), 0);
    e1_q.delete();
    e2_q.delete();
    vcnt = 0;

    // Follow-up WRITE must start with EAQ1
    load_eaq(8, 8'h03);
    for (int i = 0; i < 8; i++) begin
      exp_wr.push_back({8'hE1, 8'h03, 48'(i)});
      exp_wr.push_back({8'hE2, 8'h03, 48'(i)});
    end
    exp_cmd.push_back('{addr: 32'h2000_3000, len: 8'd16, wr: 1'b1, vcyc: 1});
    isa_q.push_back({2'b10, 32'h2000_3000});
    wait_done(6);

`ifdef AP_SCHED_TIMEOUT_EN
    // READ that never gets data: watchdog forces DONE after 32 stall cycles
    rd_hold = 1'b1;
    exp_cmd.push_back('{addr: 32'h1000_8000, len: 8'd8, wr: 1'b0, vcyc: 1});
    isa_q.push_back({2'b01, 32'h1000_8000});
    wait_done(7);
    check("t6_timeout", timeout, 1'b1);
    rd_hold = 1'b0;
`else
    check("timeout_tied_low", timeout, 1'b0);
`endif

    check("end_cmd_queue", exp_cmd.size(), 0);
    check("end_aeq_queue", exp_aeq.size(), 0);
    check("end_wr_queue", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_cmd_scheduler.md
Name: ap_cmd_scheduler

Overview:
- Sequences AI-platform instructions taken from the instruction FIFO: one 2-bit opcode plus one 32-bit address per entry.
- For each instruction it issues one DMA burst descriptor, then moves the burst's data beats.
- Read bursts move data from the DMA read FIFO to the AEQ FIFO.
- Write bursts move data from the two engine result queues (EAQ1/EAQ2) to the DMA write FIFO, with round-robin arbitration between the two queues.
- Sits between the PS-side FIFOs and the accelerator queues.

Parameters:
- ADDR_W, 32, descriptor address width.
- DATA_W, 64, data beat width.
- OP_W, 2, opcode width.
- RD_BURST, 8, beats per READ burst (1..255).
- WR_BURST, 16, beats per WRITE burst (1..255).
- TIMEOUT_CYCLES, 1024, stall limit used only when TIMEOUT_EN is defined.

Ports:
- clk in 1: clock.
- rst_n in 1: reset.
- isa_empty in 1: instruction FIFO empty.
- isa_dout in OP_W+ADDR_W: instruction entry, {op, addr}; first-word-fall-through (FWFT).
- isa_rd_en out 1: instruction FIFO pop.
- dma_cmd_valid out 1: descriptor valid.
- dma_cmd_ready in 1: descriptor accepted.
- dma_cmd_addr out ADDR_W: descriptor address.
- dma_cmd_len out 8: burst length in beats.
- dma_cmd_wr out 1: 1 = write burst, 0 = read burst.
- dma_rd_empty in 1, dma_rd_dout in DATA_W, dma_rd_en out 1: DMA read FIFO (FWFT).
- aeq_full in 1, aeq_din out DATA_W, aeq_wr_en out 1: AEQ FIFO.
- eaq1_empty in 1, eaq1_dout in DATA_W, eaq1_rd_en out 1: EAQ1 FIFO (FWFT).
- eaq2_empty in 1, eaq2_dout in DATA_W, eaq2_rd_en out 1: EAQ2 FIFO (FWFT).
- dma_wr_full in 1, dma_wr_din out DATA_W, dma_wr_en out 1: DMA write FIFO.
- busy out 1: state is not IDLE.
- done out 1: one-cycle pulse per completed burst.
- err out 1: sticky, illegal opcode seen.
- timeout out 1: sticky watchdog flag; tied to 0 without TIMEOUT_EN.

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
  - While rst_n=0: state=IDLE, all enables/valid/done/err/timeout=0, beat counter=0, rr=0 (EAQ1 preferred).
  - Reset mid-burst aborts without a done pulse; partial beats are lost.
- Opcodes:
  - 00: NOP.
  - 01: READ.
  - 10: WRITE.
  - 11: illegal.
- FSM states: IDLE, CMD, RD_XFER, WR_XFER, DONE.
- IDLE:
  - When !isa_empty, assert isa_rd_en (combinational, 1 cycle) and latch op/addr.
  - 01 or 10 -> CMD.
  - 00 -> stay IDLE.
  - 11 -> err<=1, stay IDLE.
  - At most one pop per cycle.
- CMD:
  - dma_cmd_valid=1; addr/len/wr come from registers and are stable until the handshake.
  - dma_cmd_len is RD_BURST for READ, WR_BURST for WRITE; dma_cmd_wr=op[1].
  - On valid&&ready, load beat_cnt and go to RD_XFER or WR_XFER. No timeout applies in CMD.
- RD_XFER:
  - A beat fires when !dma_rd_empty && !aeq_full.
  - On a beat: dma_rd_en=aeq_wr_en=1 and aeq_din=dma_rd_dout. Zero-latency combinational pass-through.
  - beat_cnt decrements per beat; on the last beat -> DONE.
- WR_XFER:
  - A grant needs !dma_wr_full. The preferred source is rr if it is non-empty, otherwise the other source if non-empty.
  - The granted source gets its rd_en=1; dma_wr_en=1 and dma_wr_din=granted dout.
  - After a grant to source s, rr<=~s.
  - When both sources are non-empty, grants alternate strictly.
  - rr persists across bursts.
- DONE: done=1 for one cycle, -> IDLE.
  - Minimum spacing between instructions: 3 cycles plus burst length.
- beat_cnt is 8-bit; it never underflows because the exit happens at value 1.
- All FIFO enables are gated by their own empty/full flags; they are never asserted into a full or empty FIFO.

Optional Feature:
- Macro: AP_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit stall counter increments on each XFER cycle with no beat and clears on any beat.
  - At TIMEOUT_CYCLES it sets timeout<=1 (sticky until reset), forces DONE without completing the burst, and the done pulse still fires.
- When undefined: no counter; timeout is constantly 0; bursts wait indefinitely.

Decomposition:
- Package ap_sched_pkg:
  - State enum.
  - Opcode constants OP_NOP=2'b00, OP_READ=2'b01, OP_WRITE=2'b10, OP_ILL=2'b11.
  - Default burst lengths.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], en.
  - Outputs: one-hot gnt[1:0].
  - Holds the rr register.

Test Plan:
- READ addr 0x1000_0000, dma_cmd_ready delayed 3 cycles -> dma_cmd_valid high 3 cycles, addr/len=8/wr=0 stable; 8 beats forwarded dma_rd_dout->aeq_din; single done pulse.
- WRITE with EAQ1 and EAQ2 both always non-empty -> dma_cmd_len=16, wr=1; grant order 1,2,1,2...; 8 beats from each; next WRITE starts with EAQ1.
- READ with aeq_full high during beats 3-5 -> no dma_rd_en/aeq_wr_en while full; exactly 8 beats total; data order preserved.
- Queue opcode 11, then 00, then READ -> err=1 after the first pop; no descriptor for 11 or 00; READ executes normally; three isa_rd_en pulses.
- rst_n low for 1 cycle after 5 WRITE beats -> next cycle all outputs 0, busy=0, rr=EAQ1, no done; a subsequent instruction runs cleanly.
- With AP_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=32, READ with dma_rd_empty held high -> timeout=1 after 32 stall cycles; done pulses; returns to IDLE.
